// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin memory-port arbiter.
// Masters are indexed from 0; the pick helper handles up to MAX_N masters.
package arbiter_pkg;

  localparam int MAX_N = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Result of a round-robin pick: whether anyone was eligible, and who.
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] id;
  } grant_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Rotate so ptr sits at bit 0, take the lowest set bit, map back to a master index.
  function automatic grant_t rr_pick(input logic [MAX_N-1:0] elig,
                                     input logic [IDX_W-1:0] ptr,
                                     input int               n);
    logic [MAX_N-1:0] rot;
    grant_t           g;
    int               j;
    rot = '0;
    g   = '0;
    for (int k = 0; k < MAX_N; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n) rot[k] = elig[j[IDX_W-1:0]];
    end
    for (int k = MAX_N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        g.vld = 1'b1;
        g.id  = j[IDX_W-1:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order queue of master ids for outstanding reads; data at the head is visible combinationally.
// Push is dropped when full unless a pop happens in the same cycle; pop on empty is ignored.
module arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clkSYS,
  input  logic         n_reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rp];

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clkSYS) begin
    if (do_push) mem[wp] <= push_dat;
  end

endmodule

// File: rtl/arbiter_rr.sv
// Round-robin arbiter of N masters onto one memory port; grant 1 cycle after req, ack same cycle as mem_ack.
// Read data returns 1 cycle after mem_rvalid; reads stall while the id queue is full, writes never do.
module arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int AN    = 24,
  parameter int DN    = 16,
  parameter int DEPTH = 4
) (
  input  logic            clkSYS,
  input  logic            n_reset,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    ack,
  input  logic [N*AN-1:0] addr,
  input  logic [N*DN-1:0] data,
  input  logic [N-1:0]    wr,
  output logic [DN-1:0]   rdata,
  output logic [N-1:0]    rvalid,
  output logic            mem_req,
  input  logic            mem_ack,
  output logic [AN-1:0]   mem_addr,
  output logic [DN-1:0]   mem_data,
  output logic            mem_wr,
  input  logic [DN-1:0]   mem_rdata,
  input  logic            mem_rvalid,
  output logic            err
);

  localparam int IW = id_w(N);

  state_e          state_q, state_d;
  logic [IW-1:0]   g_q, last_q, ptr, fifo_head;
  logic [N-1:0]    elig;
  grant_t          pick;
  logic            fifo_full, fifo_empty, push, pop, done;

  assign pop  = mem_rvalid && !fifo_empty;
  assign done = (state_q == BUSY) && mem_ack;
  assign push = done && !mem_wr;
  assign ptr  = (last_q == IW'(N - 1)) ? '0 : last_q + 1'b1;

  // A read may only be granted if its id will have a slot once this cycle's pop lands.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) elig[i] = req[i] && (wr[i] || !fifo_full || pop);
  end

  assign pick = rr_pick(MAX_N'(elig), IDX_W'(ptr), N);

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick.vld) state_d = BUSY;
      BUSY:    if (mem_ack)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (done) ack[g_q] = 1'b1;
  end

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      g_q      <= '0;
      last_q   <= IW'(N - 1);
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_wr   <= 1'b0;
      rvalid   <= '0;
      rdata    <= '0;
      err      <= 1'b0;
    end else begin
      if (state_q == IDLE && pick.vld) begin
        g_q      <= IW'(pick.id);
        mem_req  <= 1'b1;
        mem_addr <= addr[pick.id*AN +: AN];
        mem_data <= data[pick.id*DN +: DN];
        mem_wr   <= wr[pick.id];
      end
      if (done) begin
        mem_req <= 1'b0;
        last_q  <= g_q;
      end
      rvalid <= '0;
      if (pop) begin
        rvalid[fifo_head] <= 1'b1;
        rdata             <= mem_rdata;
      end
      if (mem_rvalid && fifo_empty) err <= 1'b1;
    end
  end

  arb_id_fifo #(
    .DEPTH (DEPTH),
    .W     (IW)
  ) u_id_fifo (
    .clkSYS   (clkSYS),
    .n_reset  (n_reset),
    .push     (push),
    .push_dat (g_q),
    .pop      (pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule
